// File: rtl/gost89_pkg.sv
// Shared types and key schedule for the GOST 28147-89 block engine.
package gost89_pkg;

    localparam int NUM_ROUNDS = 32;

    typedef logic [63:0]  block_t;
    typedef logic [31:0]  half_t;
    typedef logic [255:0] key_t;
    typedef logic [511:0] sbox_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic {ENC, DEC} mode_e;
    typedef enum logic {ECB, CBC} chain_e;

    // Encrypt walks K0..K7 three times then K7..K0; decrypt is the mirror image.
    function automatic logic [2:0] key_index(input logic [4:0] round, input mode_e mode);
        logic rev;
        rev = (mode == ENC) ? (round >= 5'd24) : (round >= 5'd8);
        return rev ? ~round[2:0] : round[2:0];
    endfunction

    // K0 sits in the top word of the key bus.
    function automatic half_t key_word(input key_t key, input logic [2:0] idx);
        return key[255 - 32*int'(idx) -: 32];
    endfunction

endpackage

// File: rtl/gost89_block_engine_if.sv
// Block input/output handshake bundle for the GOST engine.
interface gost89_block_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        mode;
    logic        chain_mode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (output in_valid, in_data, mode, chain_mode, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, mode, chain_mode, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/gost89_round.sv
// One combinational GOST Feistel round: add key, S-box, rotate 11, xor, swap.
module gost89_round
    import gost89_pkg::*;
(
    input  sbox_t sbox,
    input  half_t rkey,
    input  half_t n1_i,
    input  half_t n2_i,
    output half_t n1_o,
    output half_t n2_o
);
    half_t      sum;
    half_t      sub;
    logic [3:0] nib;

    assign sum = n1_i + rkey;

    // Row j (top 64 bits = row 0) substitutes nibble j; entry 0 is the row's top nibble.
    always_comb begin
        sub = '0;
        nib = '0;
        for (int j = 0; j < 8; j++) begin
            nib = sum[4*j +: 4];
            sub[4*j +: 4] = sbox[511 - 64*j - 4*int'(nib) -: 4];
        end
    end

    assign n1_o = n2_i ^ {sub[20:0], sub[31:21]};
    assign n2_o = n1_i;
endmodule

// File: rtl/gost89_block_engine.sv
// GOST 28147-89 ECB/CBC engine, ROUNDS_PER_CYCLE rounds per clock with valid/ready on both sides.
module gost89_block_engine
    import gost89_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit CBC_EN           = 1'b1
) (
    input  logic   clk,
    input  logic   reset,
    input  sbox_t  sbox,
    input  key_t   key,
    input  block_t iv,
    input  logic   iv_load,
    output logic   busy,
    gost89_block_engine_if.slave bus
);
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [4:0] R5       = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] LAST_CNT = 5'(NUM_ROUNDS - ROUNDS_PER_CYCLE);

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    half_t      n1_q, n1_d, n2_q, n2_d;
    block_t     hold_q, hold_d, chain_q, chain_d, out_data_q, out_data_d;
    mode_e      mode_q, mode_d;
    chain_e     cmode_q, cmode_d;
    logic       out_valid_q, out_valid_d, busy_q, busy_d;
    logic       accept, out_fire, iv_ld, cbc;
    block_t     chain_eff, result, blk_in;
    half_t      n1_fin, n2_fin;

    for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_rnd
        half_t n1_i, n2_i, n1_o, n2_o;
        if (r == 0) begin : g_first
            assign n1_i = n1_q;
            assign n2_i = n2_q;
        end else begin : g_next
            assign n1_i = g_rnd[r-1].n1_o;
            assign n2_i = g_rnd[r-1].n2_o;
        end
        gost89_round u_round (
            .sbox (sbox),
            .rkey (key_word(key, key_index(cnt_q + 5'(r), mode_q))),
            .n1_i (n1_i),
            .n2_i (n2_i),
            .n1_o (n1_o),
            .n2_o (n2_o)
        );
    end
    assign n1_fin = g_rnd[ROUNDS_PER_CYCLE-1].n1_o;
    assign n2_fin = g_rnd[ROUNDS_PER_CYCLE-1].n2_o;

    assign bus.in_ready  = reset && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;

    always_comb begin
        cbc       = CBC_EN && (cmode_q == CBC);
        accept    = bus.in_valid && bus.in_ready;
        out_fire  = out_valid_q && bus.out_ready;
        iv_ld     = CBC_EN && iv_load && ((state_q == IDLE) || (state_q == DONE && out_fire));
        chain_eff = iv_ld ? iv : chain_q;
        // Rounds end with the halves swapped once too often; undo it here.
        result    = {n2_q, n1_q};
        blk_in    = bus.in_data;

        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        n1_d        = n1_q;
        n2_d        = n2_q;
        hold_d      = hold_q;
        chain_d     = chain_eff;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        mode_d      = mode_q;
        cmode_d     = cmode_q;

        case (state_q)
            RUN: begin
                if (!last_q) begin
                    n1_d   = n1_fin;
                    n2_d   = n2_fin;
                    cnt_d  = cnt_q + R5;
                    last_d = (cnt_q == LAST_CNT);
                end else begin
                    last_d      = 1'b0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = (cbc && mode_q == DEC) ? (result ^ chain_q) : result;
                    if (cbc) chain_d = (mode_q == ENC) ? result : hold_q;
                end
            end
            DONE: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            mode_d  = mode_e'(bus.mode);
            cmode_d = chain_e'(bus.chain_mode);
            hold_d  = bus.in_data;
            if (CBC_EN && bus.chain_mode && !bus.mode) blk_in = bus.in_data ^ chain_eff;
            n1_d    = blk_in[63:32];
            n2_d    = blk_in[31:0];
            cnt_d   = '0;
            last_d  = 1'b0;
            state_d = RUN;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            n1_q        <= '0;
            n2_q        <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mode_q      <= ENC;
            cmode_q     <= ECB;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            n1_q        <= n1_d;
            n2_q        <= n2_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            mode_q      <= mode_d;
            cmode_q     <= cmode_d;
        end
    end

    if (CBC_EN) begin : g_chain
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) chain_q <= '0;
            else        chain_q <= chain_d;
        end
    end else begin : g_no_chain
        assign chain_q = '0;
    end
endmodule
